// File: rtl/madgwick_wb_ctrl_pkg.sv
// Shared widths, register map, bit indices and FSM states for the Madgwick
// filter Wishbone controller.
package madgwick_pkg;

  localparam int unsigned DefAccWidth  = 16;
  localparam int unsigned DefGyroWidth = 16;
  localparam int unsigned DefQWidth    = 32;
  localparam int unsigned DefFifoDepth = 4;
  localparam int unsigned AddrW        = 6;

  localparam logic [AddrW-1:0] AddrCtrl   = 6'h00;
  localparam logic [AddrW-1:0] AddrStatus = 6'h04;
  localparam logic [AddrW-1:0] AddrAx     = 6'h08;
  localparam logic [AddrW-1:0] AddrAy     = 6'h0C;
  localparam logic [AddrW-1:0] AddrAz     = 6'h10;
  localparam logic [AddrW-1:0] AddrWx     = 6'h14;
  localparam logic [AddrW-1:0] AddrWy     = 6'h18;
  localparam logic [AddrW-1:0] AddrWz     = 6'h1C;
  localparam logic [AddrW-1:0] AddrQw     = 6'h20;
  localparam logic [AddrW-1:0] AddrQx     = 6'h24;
  localparam logic [AddrW-1:0] AddrQy     = 6'h28;
  localparam logic [AddrW-1:0] AddrQz     = 6'h2C;
  localparam logic [AddrW-1:0] AddrCnt    = 6'h30;
  localparam logic [AddrW-1:0] AddrIrq    = 6'h34;

  localparam int unsigned CtrlEnable = 0;
  localparam int unsigned CtrlCont   = 1;
  localparam int unsigned CtrlIrqEn  = 2;
  localparam int unsigned CtrlStart  = 3;
  localparam int unsigned CtrlFlush  = 4;

  localparam int unsigned IrqDone = 0;
  localparam int unsigned IrqOvf  = 1;

  typedef enum logic [1:0] {
    StIdle,
    StIssue,
    StWait
  } state_e;

endpackage

// File: rtl/madgwick_wb_ctrl_if.sv
// Wishbone classic slave bus between the host and the filter controller.
interface madgwick_wb_ctrl_if;
  import madgwick_pkg::*;

  logic [AddrW-1:0] adr_i;
  logic [31:0]      dat_i;
  logic [31:0]      dat_o;
  logic             we_i;
  logic             stb_i;
  logic             cyc_i;
  logic             ack_o;

  modport master (output adr_i, dat_i, we_i, stb_i, cyc_i, input dat_o, ack_o);
  modport slave  (input adr_i, dat_i, we_i, stb_i, cyc_i, output dat_o, ack_o);

endinterface

// File: rtl/madgwick_wb_ctrl_fifo.sv
// Sample FIFO; a push into a full FIFO succeeds only alongside a pop, and a
// flush wins over any same-cycle push or pop.
module madgwick_sample_fifo #(
  parameter int unsigned WIDTH = 96,
  parameter int unsigned DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_flush,
  input  logic                     i_push,
  input  logic [WIDTH-1:0]         i_data,
  input  logic                     i_pop,
  output logic [WIDTH-1:0]         o_data,
  output logic                     o_empty,
  output logic                     o_full,
  output logic [$clog2(DEPTH):0]   o_level,
  output logic                     o_drop
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam logic [PtrW:0] FullLevel = (PtrW+1)'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PtrW-1:0]  r_wr_ptr;
  logic [PtrW-1:0]  r_rd_ptr;
  logic [PtrW:0]    r_level;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_level == '0);
  assign o_full  = (r_level == FullLevel);
  assign o_level = r_level;
  assign o_data  = r_mem[r_rd_ptr];
  assign w_pop   = i_pop && !o_empty && !i_flush;
  assign w_push  = i_push && !i_flush && (!o_full || w_pop);
  assign o_drop  = i_push && !i_flush && !w_push;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else if (i_flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_level  <= '0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_data;
        r_wr_ptr        <= r_wr_ptr + 1'b1;
      end
      if (w_pop) r_rd_ptr <= r_rd_ptr + 1'b1;
      r_level <= r_level + (PtrW+1)'(w_push) - (PtrW+1)'(w_pop);
    end
  end

endmodule

// File: rtl/madgwick_wb_ctrl.sv
// Wishbone register front-end that queues IMU samples, feeds them to the
// Madgwick filter core one at a time and captures the resulting quaternion.
module madgwick_wb_ctrl import madgwick_pkg::*; #(
  parameter int unsigned ACC_WIDTH  = DefAccWidth,
  parameter int unsigned GYRO_WIDTH = DefGyroWidth,
  parameter int unsigned Q_WIDTH    = DefQWidth,
  parameter int unsigned FIFO_DEPTH = DefFifoDepth
) (
  input  logic                  clk,
  input  logic                  rst_n,
  madgwick_wb_ctrl_if.slave     wb,
  output logic                  irq_o,
  output logic                  core_rst_n,
  output logic                  core_valid_in,
  input  logic                  core_ready_in,
  output logic [ACC_WIDTH-1:0]  core_a_x,
  output logic [ACC_WIDTH-1:0]  core_a_y,
  output logic [ACC_WIDTH-1:0]  core_a_z,
  output logic [GYRO_WIDTH-1:0] core_w_x,
  output logic [GYRO_WIDTH-1:0] core_w_y,
  output logic [GYRO_WIDTH-1:0] core_w_z,
  input  logic                  core_valid_out,
  output logic                  core_ready_out,
  input  logic [Q_WIDTH-1:0]    core_q_w,
  input  logic [Q_WIDTH-1:0]    core_q_x,
  input  logic [Q_WIDTH-1:0]    core_q_y,
  input  logic [Q_WIDTH-1:0]    core_q_z
);

  localparam int unsigned SampleW = 3 * ACC_WIDTH + 3 * GYRO_WIDTH;
  localparam int unsigned LvlW    = $clog2(FIFO_DEPTH) + 1;

  logic                  r_ack;
  logic [31:0]           r_dat;
  logic                  r_enable, r_en_prev, r_cont, r_irq_en, r_start_pend;
  logic                  r_core_rst_n;
  logic [ACC_WIDTH-1:0]  r_ax, r_ay, r_az;
  logic [GYRO_WIDTH-1:0] r_wx, r_wy, r_wz;
  logic [Q_WIDTH-1:0]    r_qw, r_qx, r_qy, r_qz;
  logic [31:0]           r_cnt;
  logic                  r_done, r_ovf;
  logic                  r_valid_in, r_ready_out;
  state_e                r_state;

  logic                  w_acc, w_wr, w_ctrl_wr, w_irq_wr, w_start, w_flush_wr;
  logic                  w_push, w_pop, w_go, w_done_set, w_fifo_flush;
  logic                  w_fifo_empty, w_fifo_full, w_fifo_drop;
  logic [LvlW-1:0]       w_level;
  logic [SampleW-1:0]    w_head;
  logic [31:0]           w_rdata;
  logic                  unused_dat;

  assign w_acc      = wb.cyc_i && wb.stb_i && !r_ack;
  assign w_wr       = w_acc && wb.we_i;
  assign w_ctrl_wr  = w_wr && (wb.adr_i == AddrCtrl);
  assign w_irq_wr   = w_wr && (wb.adr_i == AddrIrq);
  assign w_start    = w_ctrl_wr && wb.dat_i[CtrlStart];
  assign w_flush_wr = w_ctrl_wr && wb.dat_i[CtrlFlush];
  assign w_push     = w_wr && (wb.adr_i == AddrWz);
  assign unused_dat = ^wb.dat_i;

  // Falling enable empties the FIFO one cycle after the CTRL write lands.
  assign w_fifo_flush = w_flush_wr || (r_en_prev && !r_enable);
  assign w_pop        = r_enable && (r_state == StIssue) && r_valid_in && core_ready_in;
  assign w_go         = r_enable && (r_state == StIdle) && !w_fifo_empty && !w_fifo_flush &&
                        (r_cont || r_start_pend);
  assign w_done_set   = r_enable && (r_state == StWait) && core_valid_out;

  madgwick_sample_fifo #(
    .WIDTH (SampleW),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_flush (w_fifo_flush),
    .i_push  (w_push),
    .i_data  ({r_ax, r_ay, r_az, r_wx, r_wy, wb.dat_i[GYRO_WIDTH-1:0]}),
    .i_pop   (w_pop),
    .o_data  (w_head),
    .o_empty (w_fifo_empty),
    .o_full  (w_fifo_full),
    .o_level (w_level),
    .o_drop  (w_fifo_drop)
  );

  assign {core_a_x, core_a_y, core_a_z, core_w_x, core_w_y, core_w_z} = w_head;
  assign core_valid_in  = r_valid_in;
  assign core_ready_out = r_ready_out;
  assign core_rst_n     = r_core_rst_n;
  assign wb.ack_o       = r_ack;
  assign wb.dat_o       = r_dat;
  assign irq_o          = r_irq_en && (r_done || r_ovf);

  always_comb begin
    w_rdata = '0;
    case (wb.adr_i)
      AddrCtrl: begin
        w_rdata[CtrlEnable] = r_enable;
        w_rdata[CtrlCont]   = r_cont;
        w_rdata[CtrlIrqEn]  = r_irq_en;
      end
      AddrStatus: begin
        w_rdata[0]    = (r_state != StIdle);
        w_rdata[1]    = w_fifo_empty;
        w_rdata[2]    = w_fifo_full;
        w_rdata[15:8] = 8'(w_level);
      end
      AddrAx:  w_rdata = 32'(r_ax);
      AddrAy:  w_rdata = 32'(r_ay);
      AddrAz:  w_rdata = 32'(r_az);
      AddrWx:  w_rdata = 32'(r_wx);
      AddrWy:  w_rdata = 32'(r_wy);
      AddrWz:  w_rdata = 32'(r_wz);
      AddrQw:  w_rdata = 32'($signed(r_qw));
      AddrQx:  w_rdata = 32'($signed(r_qx));
      AddrQy:  w_rdata = 32'($signed(r_qy));
      AddrQz:  w_rdata = 32'($signed(r_qz));
      AddrCnt: w_rdata = r_cnt;
      AddrIrq: begin
        w_rdata[IrqDone] = r_done;
        w_rdata[IrqOvf]  = r_ovf;
      end
      default: w_rdata = '0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack        <= 1'b0;
      r_dat        <= '0;
      r_enable     <= 1'b0;
      r_en_prev    <= 1'b0;
      r_cont       <= 1'b0;
      r_irq_en     <= 1'b0;
      r_start_pend <= 1'b0;
      r_core_rst_n <= 1'b0;
      r_ax         <= '0;
      r_ay         <= '0;
      r_az         <= '0;
      r_wx         <= '0;
      r_wy         <= '0;
      r_wz         <= '0;
      r_done       <= 1'b0;
      r_ovf        <= 1'b0;
    end else begin
      r_ack        <= w_acc;
      r_dat        <= (w_acc && !wb.we_i) ? w_rdata : '0;
      r_en_prev    <= r_enable;
      r_core_rst_n <= r_enable;
      if (w_ctrl_wr) begin
        r_enable <= wb.dat_i[CtrlEnable];
        r_cont   <= wb.dat_i[CtrlCont];
        r_irq_en <= wb.dat_i[CtrlIrqEn];
      end
      if (w_wr) begin
        case (wb.adr_i)
          AddrAx:  r_ax <= wb.dat_i[ACC_WIDTH-1:0];
          AddrAy:  r_ay <= wb.dat_i[ACC_WIDTH-1:0];
          AddrAz:  r_az <= wb.dat_i[ACC_WIDTH-1:0];
          AddrWx:  r_wx <= wb.dat_i[GYRO_WIDTH-1:0];
          AddrWy:  r_wy <= wb.dat_i[GYRO_WIDTH-1:0];
          AddrWz:  r_wz <= wb.dat_i[GYRO_WIDTH-1:0];
          default: ;
        endcase
      end
      if (w_fifo_flush)  r_start_pend <= 1'b0;
      else if (w_start)  r_start_pend <= 1'b1;
      else if (w_go)     r_start_pend <= 1'b0;
      // Set events win over a same-cycle write-1-to-clear.
      r_done <= (r_done && !(w_irq_wr && wb.dat_i[IrqDone])) || w_done_set;
      r_ovf  <= (r_ovf && !(w_irq_wr && wb.dat_i[IrqOvf])) || w_fifo_drop;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= StIdle;
      r_valid_in  <= 1'b0;
      r_ready_out <= 1'b0;
      r_qw        <= '0;
      r_qx        <= '0;
      r_qy        <= '0;
      r_qz        <= '0;
      r_cnt       <= '0;
    end else if (!r_enable) begin
      r_state     <= StIdle;
      r_valid_in  <= 1'b0;
      r_ready_out <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (w_go) begin
            r_state    <= StIssue;
            r_valid_in <= 1'b1;
          end
        end
        StIssue: begin
          if (core_ready_in) begin
            r_state     <= StWait;
            r_valid_in  <= 1'b0;
            r_ready_out <= 1'b1;
          end
        end
        StWait: begin
          if (core_valid_out) begin
            r_state     <= StIdle;
            r_ready_out <= 1'b0;
            r_qw        <= core_q_w;
            r_qx        <= core_q_x;
            r_qy        <= core_q_y;
            r_qz        <= core_q_z;
            r_cnt       <= r_cnt + 32'd1;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_madgwick_wb_ctrl.sv
// Self-checking bench for madgwick_wb_ctrl: register table, directed corner
// sequences and randomized batches against a queue-based model.
module tb_madgwick_wb_ctrl;
  import madgwick_pkg::*;

  localparam int unsigned AW = 16, GW = 16, QWD = 32, DEPTH = 4;
  typedef logic [95:0] sample_t;
  typedef struct {
    logic        wr;
    logic [5:0]  adr;
    logic [31:0] wd;
    logic [31:0] exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  madgwick_wb_ctrl_if wb_if();
  logic irq, core_rst_n, core_valid_in, core_ready_out;
  logic core_ready_in = 1'b0;
  logic core_valid_out = 1'b0;
  logic [AW-1:0] ax, ay, az;
  logic [GW-1:0] wx, wy, wz;
  logic [QWD-1:0] c_qw = '0, c_qx = '0, c_qy = '0, c_qz = '0;

  madgwick_wb_ctrl #(
    .ACC_WIDTH (AW), .GYRO_WIDTH (GW), .Q_WIDTH (QWD), .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk (clk), .rst_n (rst_n), .wb (wb_if), .irq_o (irq), .core_rst_n (core_rst_n),
    .core_valid_in (core_valid_in), .core_ready_in (core_ready_in),
    .core_a_x (ax), .core_a_y (ay), .core_a_z (az),
    .core_w_x (wx), .core_w_y (wy), .core_w_z (wz),
    .core_valid_out (core_valid_out), .core_ready_out (core_ready_out),
    .core_q_w (c_qw), .core_q_x (c_qx), .core_q_y (c_qy), .core_q_z (c_qz)
  );

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  // Core model: handshake log plus a responder with programmable latency.
  sample_t hs_q[$];
  always @(negedge clk)
    if (rst_n && core_valid_in && core_ready_in) hs_q.push_back({ax, ay, az, wx, wy, wz});

  logic bp_hold = 1'b0, rnd_ready = 1'b0, resp_en = 1'b1;
  int   resp_lat = 1;
  int   lat_cnt = 0;
  initial forever begin
    @(posedge clk); #2;
    core_ready_in = bp_hold ? 1'b0 : (rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1);
    if (core_valid_out) core_valid_out = 1'b0;
    else if (core_ready_out && resp_en) begin
      if (lat_cnt >= resp_lat) begin
        core_valid_out = 1'b1;
        lat_cnt = 0;
      end else lat_cnt++;
    end
  end

  task automatic wb_xfer(input logic we, input logic [5:0] adr, input logic [31:0] wd,
                         output logic [31:0] rd);
    int t = 0;
    @(posedge clk); #2;
    wb_if.cyc_i = 1'b1; wb_if.stb_i = 1'b1; wb_if.we_i = we;
    wb_if.adr_i = adr;  wb_if.dat_i = wd;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!wb_if.ack_o && t < 8);
    rd = wb_if.dat_o;
    if (!wb_if.ack_o) begin
      n_vec++; n_err++;
      $display("FAIL wb_ack: got no ack at adr %0h, expected ack within 8 cycles", adr);
    end
    #1;
    wb_if.cyc_i = 1'b0; wb_if.stb_i = 1'b0; wb_if.we_i = 1'b0;
  endtask

  task automatic wb_wr(input logic [5:0] adr, input logic [31:0] wd);
    logic [31:0] dummy;
    wb_xfer(1'b1, adr, wd, dummy);
  endtask

  task automatic rd_check(input string name, input logic [5:0] adr, input logic [31:0] exp);
    logic [31:0] rd;
    wb_xfer(1'b0, adr, 32'h0, rd);
    check(name, rd, exp);
  endtask

  task automatic push_sample(input sample_t s);
    wb_wr(AddrAx, {16'($urandom()), s[95:80]});
    wb_wr(AddrAy, {16'($urandom()), s[79:64]});
    wb_wr(AddrAz, {16'($urandom()), s[63:48]});
    wb_wr(AddrWx, {16'($urandom()), s[47:32]});
    wb_wr(AddrWy, {16'($urandom()), s[31:16]});
    wb_wr(AddrWz, {16'($urandom()), s[15:0]});
  endtask

  function automatic sample_t rand_sample();
    return {$urandom(), $urandom(), $urandom()};
  endfunction

  task automatic wait_updates(input logic [31:0] target, input string name);
    logic [31:0] rd;
    int t = 0;
    do begin
      wb_xfer(1'b0, AddrCnt, 32'h0, rd);
      t++;
    end while (rd != target && t < 100);
    check(name, rd, target);
  endtask

  task automatic wait_valid_in(input string name);
    int t = 0;
    while (!core_valid_in && t < 30) begin
      @(negedge clk);
      t++;
    end
    check(name, core_valid_in, 1'b1);
  endtask

  task automatic check_hs(input string name, input sample_t exp_q[$]);
    check({name, "_count"}, hs_q.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < hs_q.size(); i++)
      check($sformatf("%s_%0d", name, i), hs_q[i], exp_q[i]);
  endtask

  task automatic do_reset();
    @(posedge clk); #2;
    rst_n = 1'b0;
    wb_if.cyc_i = 1'b0; wb_if.stb_i = 1'b0; wb_if.we_i = 1'b0;
    bp_hold = 1'b0; rnd_ready = 1'b0; resp_en = 1'b1;
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    hs_q.delete();
  endtask

  vec_t    tbl[13];
  sample_t exp_q[$];
  sample_t s;
  logic [31:0] mcnt;
  int          n, lvl, bad;

  initial begin
    wb_if.adr_i = '0; wb_if.dat_i = '0;
    wb_if.cyc_i = 1'b0; wb_if.stb_i = 1'b0; wb_if.we_i = 1'b0;
    tbl[0]  = '{1'b0, AddrCtrl,   32'h0,        32'h0};
    tbl[1]  = '{1'b0, AddrStatus, 32'h0,        32'h2};
    tbl[2]  = '{1'b0, AddrCnt,    32'h0,        32'h0};
    tbl[3]  = '{1'b0, AddrIrq,    32'h0,        32'h0};
    tbl[4]  = '{1'b0, AddrQw,     32'h0,        32'h0};
    tbl[5]  = '{1'b1, AddrAx,     32'hDEAD1234, 32'h1234};
    tbl[6]  = '{1'b1, AddrAy,     32'h0000FFFF, 32'hFFFF};
    tbl[7]  = '{1'b1, AddrWx,     32'hFFFF8001, 32'h8001};
    tbl[8]  = '{1'b1, 6'h38,      32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{1'b1, AddrCtrl,   32'h1C,       32'h4};
    tbl[10] = '{1'b1, AddrStatus, 32'hFF,       32'h2};
    tbl[11] = '{1'b1, AddrIrq,    32'h3,        32'h0};
    tbl[12] = '{1'b1, AddrCtrl,   32'h0,        32'h0};

    #1;
    check("rst_pins", {wb_if.ack_o, wb_if.dat_o, irq, core_rst_n, core_valid_in,
                       core_ready_out}, '0);
    do_reset();
    check("rst_core_rst_n", core_rst_n, 1'b0);
    for (int i = 0; i < 13; i++) begin
      if (tbl[i].wr) wb_wr(tbl[i].adr, tbl[i].wd);
      rd_check($sformatf("tbl%0d", i), tbl[i].adr, tbl[i].exp);
    end

    // Single-shot
    do_reset();
    c_qw = 32'h4000_0000; c_qx = 32'hFFFF_C000; c_qy = 32'h1; c_qz = 32'h2; resp_lat = 2;
    wb_wr(AddrCtrl, 32'h5);
    repeat (2) @(posedge clk); #1;
    check("ss_core_rst_n", core_rst_n, 1'b1);
    s = rand_sample();
    push_sample(s);
    rd_check("ss_no_start", AddrStatus, 32'h100);
    wb_wr(AddrCtrl, 32'hD);
    wait_updates(1, "ss_cnt");
    repeat (10) @(posedge clk);
    exp_q = '{s};
    check_hs("ss_hs", exp_q);
    rd_check("ss_qw", AddrQw, 32'h4000_0000);
    rd_check("ss_qx", AddrQx, 32'hFFFF_C000);
    rd_check("ss_irq_stat", AddrIrq, 32'h1);
    check("ss_irq", irq, 1'b1);
    rd_check("ss_status", AddrStatus, 32'h2);
    wb_wr(AddrIrq, 32'h1);
    rd_check("ss_w1c", AddrIrq, 32'h0);
    check("ss_irq_clr", irq, 1'b0);

    // Continuous
    do_reset();
    rnd_ready = 1'b1; resp_lat = 0;
    wb_wr(AddrCtrl, 32'h3);
    exp_q.delete();
    for (int i = 0; i < 4; i++) begin
      s = rand_sample();
      exp_q.push_back(s);
      push_sample(s);
    end
    wait_updates(4, "ct_cnt");
    repeat (5) @(posedge clk);
    check_hs("ct_hs", exp_q);
    rd_check("ct_status", AddrStatus, 32'h2);

    // Overflow
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 5; i++) begin
      s = rand_sample();
      if (i < 4) exp_q.push_back(s);
      push_sample(s);
    end
    rd_check("ov_status", AddrStatus, 32'h404);
    rd_check("ov_irq_stat", AddrIrq, 32'h2);
    check("ov_irq_masked", irq, 1'b0);
    wb_wr(AddrCtrl, 32'h4);
    check("ov_irq", irq, 1'b1);
    wb_wr(AddrIrq, 32'h2);
    rd_check("ov_w1c", AddrIrq, 32'h0);
    check("ov_irq_clr", irq, 1'b0);
    wb_wr(AddrCtrl, 32'h7);
    wait_updates(4, "ov_cnt");
    repeat (5) @(posedge clk);
    check_hs("ov_hs", exp_q);
    rd_check("ov_done", AddrIrq, 32'h1);

    // Backpressure
    do_reset();
    exp_q.delete();
    for (int i = 0; i < 2; i++) begin
      s = rand_sample();
      exp_q.push_back(s);
      push_sample(s);
    end
    bp_hold = 1'b1;
    wb_wr(AddrCtrl, 32'h3);
    wait_valid_in("bp_valid");
    bad = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (core_valid_in !== 1'b1 || {ax, ay, az, wx, wy, wz} !== exp_q[0]) bad++;
    end
    check("bp_stable", bad, 0);
    rd_check("bp_status", AddrStatus, 32'h201);
    check("bp_no_hs", hs_q.size(), 0);
    bp_hold = 1'b0;
    wait_updates(2, "bp_cnt");
    repeat (5) @(posedge clk);
    check_hs("bp_hs", exp_q);

    // Disable mid-WAIT
    do_reset();
    c_qw = 32'h4000_0000; resp_lat = 1;
    wb_wr(AddrCtrl, 32'h3);
    push_sample(rand_sample());
    wait_updates(1, "dw_cnt1");
    resp_en = 1'b0; c_qw = 32'h1234_5678;
    push_sample(rand_sample());
    push_sample(rand_sample());
    begin
      logic [31:0] rd;
      int t = 0;
      do begin
        wb_xfer(1'b0, AddrStatus, 32'h0, rd);
        t++;
      end while (rd != 32'h101 && t < 30);
      check("dw_wait_state", rd, 32'h101);
    end
    check("dw_rst_n_pre", core_rst_n, 1'b1);
    wb_wr(AddrCtrl, 32'h0);
    repeat (2) @(posedge clk); #1;
    check("dw_core_pins", {core_rst_n, core_valid_in, core_ready_out}, 3'b000);
    rd_check("dw_status", AddrStatus, 32'h2);
    rd_check("dw_qw", AddrQw, 32'h4000_0000);
    rd_check("dw_cnt", AddrCnt, 32'h1);

    // Reset mid-ISSUE
    do_reset();
    bp_hold = 1'b1;
    wb_wr(AddrCtrl, 32'h7);
    push_sample(rand_sample() | 96'h1);
    wait_valid_in("ri_valid");
    @(posedge clk); #2;
    rst_n = 1'b0;
    #1;
    check("ri_pins", {wb_if.ack_o, wb_if.dat_o, irq, core_rst_n, core_valid_in, core_ready_out,
                      ax, ay, az, wx, wy, wz}, '0);
    do_reset();
    rd_check("ri_status", AddrStatus, 32'h2);

    // Randomized batches against the queue model
    do_reset();
    mcnt = 0;
    for (int it = 0; it < 12; it++) begin
      wb_wr(AddrCtrl, 32'h4);
      n = $urandom_range(1, 6);
      lvl = (n > DEPTH) ? DEPTH : n;
      exp_q.delete();
      hs_q.delete();
      for (int i = 0; i < n; i++) begin
        s = rand_sample();
        if (i < DEPTH) exp_q.push_back(s);
        push_sample(s);
      end
      rd_check($sformatf("rn%0d_status", it), AddrStatus,
               (32'(lvl) << 8) | ((lvl == DEPTH) ? 32'h4 : 32'h0));
      rd_check($sformatf("rn%0d_ovf", it), AddrIrq, (n > DEPTH) ? 32'h2 : 32'h0);
      c_qw = $urandom(); c_qx = $urandom(); c_qy = $urandom(); c_qz = $urandom();
      rnd_ready = 1'b1;
      resp_lat = $urandom_range(0, 3);
      wb_wr(AddrCtrl, 32'h7);
      mcnt += 32'(lvl);
      wait_updates(mcnt, $sformatf("rn%0d_cnt", it));
      repeat (4) @(posedge clk);
      check_hs($sformatf("rn%0d_hs", it), exp_q);
      rd_check($sformatf("rn%0d_qw", it), AddrQw, c_qw);
      rd_check($sformatf("rn%0d_qz", it), AddrQz, c_qz);
      rd_check($sformatf("rn%0d_irqs", it), AddrIrq, (n > DEPTH) ? 32'h3 : 32'h1);
      check($sformatf("rn%0d_irq", it), irq, 1'b1);
      wb_wr(AddrIrq, 32'h3);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
